deser_align: RTL
================

# deser_align

Parametrised serial-to-parallel converter with comma-based word alignment, lock acquisition and loss-of-lock detection. It generalises the fixed 8-bit deserializer to any word width, either bit order, and a qualified serial input. It sits on the receive side of the serdes path, between the serial line sampler and the parallel word consumer.

## Interface
- WIDTH, 8: word width in bits; legal range is WIDTH ≥ 4.
- COMMA, 8'hBC (WIDTH bits): alignment pattern.
- LSB_FIRST, 1: 1 = first serial bit lands in data_out[0]; 0 = first bit lands in data_out[WIDTH-1].
- LOCK_CNT, 3: number of aligned commas needed to declare lock; ≥ 1.
- LOSS_CNT, 4: number of misaligned commas that drop lock; ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-low.
- sin  in  1  serial data bit.
- en  in  1  sin is valid this cycle; the block does nothing when en=0.
- data_out  out  WIDTH  last aligned word; registered.
- data_valid  out  1  one-cycle pulse; data_out is new.
- is_comma  out  1  data_out equals COMMA; qualified by data_valid.
- locked  out  1  state is LOCKED.

## Operation
- Shift register sr (WIDTH bits) loads one bit on each cycle with en=1.
  - LSB_FIRST=1: the new bit enters at the MSB and the register shifts right.
  - LSB_FIRST=0: the new bit enters at the LSB and the register shifts left.
- match = post-shift sr == COMMA. It is evaluated only on cycles with en=1.
- Bit counter cnt runs from 0 to WIDTH-1 and increments on en. It wraps to 0 after WIDTH-1.
- Boundary = cycle with en=1 and cnt == WIDTH-1.
- Misaligned comma = match on a cycle with en=1 and cnt != WIDTH-1.
- FSM states are HUNT, CHECK and LOCKED. The state is HUNT after reset.
  - HUNT: on match, force cnt to 0 (the next bit is bit 0 of a word), set good=1, go to CHECK. If LOCK_CNT=1, go directly to LOCKED and emit the comma word.
  - CHECK: on a boundary with match, good++. When good reaches LOCK_CNT, go to LOCKED on that same edge. On a boundary without match, stay in CHECK and keep good unchanged. On a misaligned comma, realign (cnt forced to 0, good=1) and stay in CHECK.
  - LOCKED: every boundary loads data_out with the post-shift sr, pulses data_valid, and sets is_comma=match.
    - An aligned comma clears bad.
    - A misaligned comma increments bad. When bad reaches LOSS_CNT, go to HUNT on that edge and clear bad. Alignment (cnt) is not changed in LOCKED.
- data_valid is asserted only in LOCKED and on the lock-entry edge. No words are output in HUNT or CHECK.
- Counter good uses $clog2(LOCK_CNT+1) bits and bad uses $clog2(LOSS_CNT+1) bits. Neither counter overflows, because each is reset at its threshold.

## Timing
- Reset values: sr=0, cnt=0, good=0, bad=0, state=HUNT, data_out=0, data_valid=0, is_comma=0, locked=0.
- Reset is asynchronous: asserting rst clears everything immediately, including mid-word. Lock must be reacquired afterwards.
- Latency: data_out, data_valid and is_comma update on the clock edge that samples a word's last bit. They are visible in the following cycle.
- data_valid is high for exactly one cycle per word. Minimum spacing is WIDTH cycles; spacing is longer when en has gaps.
- locked rises on the edge that samples the last bit of the LOCK_CNT-th aligned comma. That comma word is emitted with data_valid=1 and is_comma=1 on the same edge.
- locked falls on the edge of the LOSS_CNT-th misaligned comma. data_valid is 0 on that edge.
- en=0: sr, cnt, FSM and counters hold, and data_valid=0. data_out and is_comma hold.

## Configuration
- DESER_ERRCNT_EN defined: the block adds output err_cnt, 16 bits.
  - err_cnt increments on every misaligned comma seen in LOCKED, including the one that drops lock.
  - err_cnt saturates at 16'hFFFF. Only rst clears it; reset value is 0.
- DESER_ERRCNT_EN undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
Defaults for all scenarios unless stated: WIDTH=8, COMMA=8'hBC, LOCK_CNT=3, LOSS_CNT=4, LSB_FIRST=1.
- Reset: drive rst=0 mid-stream → all outputs are 0 and locked=0 asynchronously, before the next clk edge.
- Lock: send 3 random bits, then BC, BC, BC, 0x55 LSB-first with en=1 continuously.
  - locked=1 and data_valid=1 with data_out=8'hBC, is_comma=1 on the 3rd BC's last-bit edge.
  - Next, data_out=8'h55 with is_comma=0, exactly 8 cycles later.
- en gaps: while locked, insert 5 en=0 cycles inside word 0xA3 → data_out=8'hA3, with data_valid delayed by exactly 5 cycles. No spurious pulses occur.
- Loss of lock: while locked, insert one extra bit, then send 4 BC words → locked falls on the edge of the 4th misaligned comma. The FSM then reacquires on the new alignment after 3 aligned commas.
  - With DESER_ERRCNT_EN defined, err_cnt=4.
- Aligned comma clears bad: send 3 misaligned commas, 1 aligned comma, then 3 misaligned commas → locked stays 1 throughout.
- Bit order: LSB_FIRST=0, WIDTH=10, COMMA=10'h17C sent MSB-first ×3 → locked=1 and data_out=10'h17C.

Source files
------------

// File: rtl/deser_align.sv
// Serial-to-parallel converter with comma alignment, lock and loss-of-lock.
// Define DESER_ERRCNT_EN to add the saturating err_cnt output.
module deser_align #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] COMMA     = WIDTH'(8'hBC),
  parameter bit               LSB_FIRST = 1'b1,
  parameter int               LOCK_CNT  = 3,
  parameter int               LOSS_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             is_comma,
  output logic             locked
`ifdef DESER_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    good_q, good_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             isc_q, isc_d;
  logic             match, boundary;
`ifdef DESER_ERRCNT_EN
  logic [15:0]      err_q, err_d;
`endif

  assign sr_shift = LSB_FIRST ? {sin, sr_q[WIDTH-1:1]}
                              : {sr_q[WIDTH-2:0], sin};
  assign match    = en && (sr_shift == COMMA);
  assign boundary = en && (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    good_d  = good_q;
    bad_d   = bad_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    isc_d   = isc_q;
`ifdef DESER_ERRCNT_EN
    err_d   = err_q;
`endif
    if (en) begin
      sr_d  = sr_shift;
      cnt_d = boundary ? '0 : cnt_q + 1'b1;
      unique case (state_q)
        HUNT: begin
          if (match) begin
            cnt_d = '0;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              dout_d  = sr_shift;
              dv_d    = 1'b1;
              isc_d   = 1'b1;
            end else begin
              good_d  = GW'(1);
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (boundary && match) begin
            if (good_q == GW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              good_d  = '0;
              dout_d  = sr_shift;
              dv_d    = 1'b1;
              isc_d   = 1'b1;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else if (match) begin
            // comma off the current grid: adopt the new alignment
            cnt_d  = '0;
            good_d = GW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            dout_d = sr_shift;
            dv_d   = 1'b1;
            isc_d  = match;
            if (match) bad_d = '0;
          end else if (match) begin
`ifdef DESER_ERRCNT_EN
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
`endif
            if (bad_q == BW'(LOSS_CNT - 1)) begin
              state_d = HUNT;
              bad_d   = '0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      cnt_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      isc_q   <= 1'b0;
`ifdef DESER_ERRCNT_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      isc_q   <= isc_d;
`ifdef DESER_ERRCNT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign is_comma   = isc_q;
  assign locked     = (state_q == LOCKED);
`ifdef DESER_ERRCNT_EN
  assign err_cnt    = err_q;
`endif

endmodule
